// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the PR control word {select, drop, enable} and its sequencer.
// Bit positions are also imported by the downstream split logic.
package gpio_ctrl_pkg;

    localparam int GPIO_W        = 3;
    localparam int GPIO_EN_BIT   = 0;
    localparam int GPIO_DROP_BIT = 1;
    localparam int GPIO_SEL_BIT  = 2;

    localparam logic [GPIO_W-1:0] GPIO_RST = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DROP    = 2'd1,
        SWITCH  = 2'd2,
        RELEASE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gpio_merge_seq.sv
// Safe reconfiguration sequencer producing gpio = {select, drop, enable}.
// Optional macro GPIO_SEQ_SKIP_EN: a request that keeps the current select jumps straight to RELEASE.
module gpio_merge_seq
    import gpio_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_select,
    input  logic              req_enable,
    output logic [GPIO_W-1:0] gpio,
    output logic              busy,
    output logic              done
);

    seq_state_t        state_reg, state_next;
    logic [GPIO_W-1:0] gpio_reg, gpio_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              sel_reg, sel_next;
    logic              en_reg, en_next;
    logic              done_reg, done_next;
    logic              handshake;
    logic              skip;

    assign handshake = req_valid && (state_reg == IDLE);

`ifdef GPIO_SEQ_SKIP_EN
    assign skip = (req_select == gpio_reg[GPIO_SEL_BIT]);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            gpio_reg  <= GPIO_RST;
            cnt_reg   <= '0;
            sel_reg   <= 1'b0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gpio_reg  <= gpio_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gpio_next  = gpio_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        en_next    = en_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    sel_next = req_select;
                    en_next  = req_enable;
                    if (skip) begin
                        state_next               = RELEASE;
                        gpio_next[GPIO_DROP_BIT] = 1'b0;
                        gpio_next[GPIO_EN_BIT]   = req_enable;
                        done_next                = 1'b1;
                    end else begin
                        // Enable goes low together with drop so the pair is never both high.
                        state_next               = DROP;
                        gpio_next[GPIO_DROP_BIT] = 1'b1;
                        gpio_next[GPIO_EN_BIT]   = 1'b0;
                        cnt_next                 = CNT_W'(1);
                    end
                end
            end

            DROP: begin
                if (cnt_reg == CNT_W'(DRAIN_CYCLES)) begin
                    state_next              = SWITCH;
                    gpio_next[GPIO_SEL_BIT] = sel_reg;
                    cnt_next                = CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            SWITCH: begin
                if (cnt_reg == CNT_W'(SETTLE_CYCLES)) begin
                    state_next               = RELEASE;
                    gpio_next[GPIO_DROP_BIT] = 1'b0;
                    gpio_next[GPIO_EN_BIT]   = en_reg;
                    done_next                = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            RELEASE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign gpio      = gpio_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_gpio_merge_seq.sv
// Directed self-checking bench for gpio_merge_seq with default timing (drain 16, settle 8).
module tb_gpio_merge_seq;

    localparam int DRAIN  = 16;
    localparam int SETTLE = 8;
    localparam int CW     = 8;

    if (DRAIN < 1 || DRAIN > (2**CW) - 1 || SETTLE < 1 || SETTLE > (2**CW) - 1) begin : g_param_check
        $error("gpio_merge_seq timing parameters out of range");
    end

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_select = 1'b0;
    logic       req_enable = 1'b0;
    logic [2:0] gpio;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    gpio_merge_seq #(
        .DRAIN_CYCLES (DRAIN),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_select(req_select),
        .req_enable(req_enable),
        .gpio      (gpio),
        .busy      (busy),
        .done      (done)
    );

    always #5 aclk = ~aclk;

    // Invariants checked every cycle outside reset.
    logic [2:0] prev_gpio = 3'b010;
    always @(negedge aclk) begin
        if (aresetn) begin
            checks++;
            if (gpio[0] && gpio[1]) begin
                errors++;
                $display("FAIL inv_en_drop got %b want not both enable and drop", gpio);
            end
            checks++;
            if (!gpio[1] && !prev_gpio[1] && (gpio[2] !== prev_gpio[2])) begin
                errors++;
                $display("FAIL inv_sel_stable got %b after %b want select unchanged while drop low", gpio, prev_gpio);
            end
        end
        prev_gpio = gpio;
    end

    // Called just after a negedge; handshake occurs at the following posedge (cycle T).
    task automatic do_req(input logic sel, input logic en);
        req_valid  = 1'b1;
        req_select = sel;
        req_enable = en;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_handshake got %b want 1", req_ready);
        end
        @(posedge aclk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (gpio !== 3'b010) begin errors++; $display("FAIL reset_gpio got %b want 010", gpio); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        $display("reset: gpio=%b ready=%b busy=%b done=%b", gpio, req_ready, busy, done);
    endtask

    // Runs one full-length sequence starting from old_sel, checking every cycle T+1..T+26.
    task automatic run_full(input string name, input logic old_sel, input logic sel, input logic en);
        logic [2:0] exp_gpio;
        do_req(sel, en);
        for (int k = 1; k <= 26; k++) begin
            @(negedge aclk);
            if (k <= DRAIN)               exp_gpio = {old_sel, 2'b10};
            else if (k <= DRAIN + SETTLE) exp_gpio = {sel, 2'b10};
            else                          exp_gpio = {sel, 1'b0, en};
            checks++;
            if (gpio !== exp_gpio) begin
                errors++;
                $display("FAIL %s_gpio T+%0d got %b want %b", name, k, gpio, exp_gpio);
            end
            checks++;
            if (done !== (k == 25)) begin
                errors++;
                $display("FAIL %s_done T+%0d got %b want %b", name, k, done, (k == 25));
            end
            checks++;
            if (req_ready !== (k == 26) || busy !== (k != 26)) begin
                errors++;
                $display("FAIL %s_ready_busy T+%0d got %b%b want %b%b", name, k, req_ready, busy, (k == 26), (k != 26));
            end
        end
        $display("%s: sel=%b en=%b final gpio=%b", name, sel, en, gpio);
    endtask

    task automatic test_full_sequence();
        run_full("full", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_disable();
        run_full("disable", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int second_t = -1;
        req_valid  = 1'b1;
        req_select = 1'b1;
        req_enable = 1'b0;
        @(posedge aclk);
        #1 req_select = 1'b0;
        req_enable = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            @(negedge aclk);
            if (done) done_cnt++;
            if (k <= 26) begin
                checks++;
                if (req_ready !== (k == 26)) begin
                    errors++;
                    $display("FAIL b2b_ready T+%0d got %b want %b", k, req_ready, (k == 26));
                end
            end
            if (k == 25) begin
                checks++;
                if (gpio !== 3'b100) begin errors++; $display("FAIL b2b_first_gpio got %b want 100", gpio); end
            end
            if (k == 26) begin
                second_t = k;
                @(posedge aclk);
                #1 req_valid = 1'b0;
            end
            if (k == 27) begin
                checks++;
                if (gpio !== 3'b110 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_second_start got gpio=%b busy=%b want 110 1", gpio, busy);
                end
            end
        end
        checks++;
        if (gpio !== 3'b001) begin errors++; $display("FAIL b2b_final_gpio got %b want 001", gpio); end
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        $display("back_to_back: second handshake at T+%0d final gpio=%b done pulses=%0d", second_t, gpio, done_cnt);
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        do_req(1'b1, 1'b1);
        repeat (10) @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (gpio !== 3'b010 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got gpio=%b ready=%b busy=%b done=%b want 010 1 0 0", gpio, req_ready, busy, done);
        end
        repeat (30) begin
            @(negedge aclk);
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 0 || gpio !== 3'b010) begin
            errors++;
            $display("FAIL midreset_resume got done pulses=%0d gpio=%b want 0 010", done_cnt, gpio);
        end
        $display("reset_mid: gpio=%b done pulses=%0d", gpio, done_cnt);
    endtask

    task automatic test_same_select();
        run_full("prep", 1'b0, 1'b1, 1'b0);
`ifdef GPIO_SEQ_SKIP_EN
        do_req(1'b1, 1'b1);
        @(negedge aclk);
        checks++;
        if (gpio !== 3'b101 || done !== 1'b1) begin
            errors++;
            $display("FAIL skip_t1 got gpio=%b done=%b want 101 1", gpio, done);
        end
        @(negedge aclk);
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0 || gpio !== 3'b101) begin
            errors++;
            $display("FAIL skip_t2 got ready=%b done=%b gpio=%b want 1 0 101", req_ready, done, gpio);
        end
        $display("skip: gpio=%b", gpio);
`else
        run_full("same_sel", 1'b1, 1'b1, 1'b1);
`endif
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_disable();
        test_back_to_back();
        test_reset_mid();
        test_same_select();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_merge_seq.md
Name: gpio_merge_seq

Overview:
- Control-side producer of the 3-bit PR control word gpio[2:0] = {select, drop, enable}, which is split downstream into individual enable/drop/select lines.
- Accepts a one-shot reconfiguration request (target select, final enable) over a valid/ready handshake.
- Runs a safe sequence: assert drop, drain, switch select, settle, release drop, apply enable.
- Sits between the PS/AXI-GPIO control path and the split logic feeding the reconfigurable region.

Parameters:
- DRAIN_CYCLES, 16, cycles drop is held before select changes; range 1..2^CNT_W-1.
- SETTLE_CYCLES, 8, cycles held after select changes before drop releases; range 1..2^CNT_W-1.
- CNT_W, 8, width of the shared wait counter.

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_select  in  1  target select value; sampled on handshake.
- req_enable  in  1  enable value applied at end of sequence; sampled on handshake.
- gpio  out  3  packed control word: [0]=enable, [1]=drop, [2]=select; registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the RELEASE cycle.

Behaviour:
- Reset is synchronous. While aresetn=0 at a rising edge, the next state is:
  - state=IDLE, gpio=3'b010 (drop asserted, enable off, select 0), done=0, counter=0, latched request=0.
  - Drop stays high until the first completed sequence.
- Handshake:
  - A transfer occurs when req_valid && req_ready at a rising edge (cycle T).
  - req_select and req_enable are latched at T.
  - req_valid outside IDLE is ignored; no queuing.
- FSM states: IDLE, DROP, SWITCH, RELEASE. All outputs are registered and change on the edge that enters a state.
  - IDLE -> DROP on handshake. On entry: gpio[1]=1, gpio[0]=0, gpio[2] unchanged, counter=1.
  - DROP: holds for exactly DRAIN_CYCLES cycles (T+1 .. T+DRAIN_CYCLES), then -> SWITCH.
  - SWITCH: on entry gpio[2]=latched select, counter=1. Holds exactly SETTLE_CYCLES cycles, then -> RELEASE.
  - RELEASE: lasts one cycle. gpio[1]=0, gpio[0]=latched enable, done=1. Then -> IDLE with done=0.
  - IDLE: gpio holds its last value; req_ready=1, busy=0.
- Latency: done is seen at cycle T+DRAIN_CYCLES+SETTLE_CYCLES+1. req_ready is high again at T+DRAIN_CYCLES+SETTLE_CYCLES+2.
- Invariants:
  - Enable and drop are never both 1.
  - Select never changes while drop=0.
- Counter:
  - Compared with equality to the parameter.
  - Counter wrap is impossible within the legal parameter range.
  - Out-of-range parameter values are a configuration error; the bench checks them with an elaboration-time assertion.
- Reset mid-sequence: at the next edge the block returns to the reset values above. The sequence is not resumed, and no done pulse is produced.
- Same-select request (without the optional feature): runs the full sequence. gpio[2] is rewritten with an unchanged value.

Optional Feature:
- Macro: GPIO_SEQ_SKIP_EN.
- Defined: if the latched select equals the current gpio[2] at handshake, IDLE -> RELEASE directly (no DROP/SWITCH).
  - done appears at T+1; drop is cleared and enable applied in that cycle.
- Undefined: every request runs the full sequence; the comparator is not built.

Decomposition:
- Shared package gpio_ctrl_pkg holds:
  - Bit-index constants GPIO_EN_BIT=0, GPIO_DROP_BIT=1, GPIO_SEL_BIT=2.
  - GPIO_W=3 and the reset word GPIO_RST=3'b010.
  - FSM state typedef (IDLE, DROP, SWITCH, RELEASE).
- The split logic imports the same bit indices.
- Sub-module: none. The single wait counter is inline; a separate module is not warranted.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles, release -> gpio=3'b010, req_ready=1, busy=0, done=0.
- Full sequence with defaults: handshake at T with select=1, enable=1 ->
  - gpio=3'b010 for T+1..T+16, then 3'b110 for T+17..T+24.
  - gpio=3'b101 with done=1 at T+25; req_ready=1 at T+26.
- Back-to-back: req_valid held high with a changing select -> second handshake no earlier than T+26; requests during busy are not accepted; select tracks only accepted values.
- Disable request: from gpio=3'b101, request select=0, enable=0 -> enable drops to 0 at T+1; final gpio=3'b000 at T+25.
- Reset mid-sequence: assert aresetn=0 at T+10 for 1 cycle -> next cycle gpio=3'b010, state IDLE, no done pulse.
- GPIO_SEQ_SKIP_EN defined: from gpio=3'b100, request select=1, enable=1 -> gpio=3'b101 and done=1 at T+1; the drop bit never toggles.
